// File: rtl/console_pkg.sv
// -----------------------------------------------------------------------------
// console_pkg
// Shared constants and helpers for the text-mode console pixel generator:
// geometry of the character grid, prompt string, arrow-key scan codes,
// the 5x7 glyph table and the function that expands it into 9x16 cell rows.
// No ports (package).
// -----------------------------------------------------------------------------
package console_pkg;

  localparam int COLS         = 70;   // characters per text row
  localparam int CHAR_W       = 9;    // 8 glyph pixels + 1 spacing column
  localparam int CHAR_H       = 16;
  localparam int HEAD_LEN     = 9;    // prompt length in characters
  localparam int ROWS_VISIBLE = 30;
  localparam int VISIBLE_W    = 630;  // COLS * CHAR_W

  localparam logic [23:0] HEADER_COLOR = 24'h00FF00;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Leftmost prompt character sits in the most significant byte.
  localparam logic [8*HEAD_LEN-1:0] PROMPT = "MYS@bash$";

  // Column split of a scan position: cell column plus the low 4 bits of the
  // cell's base pixel (enough to recover the 0..8 in-cell offset modulo 16).
  typedef struct packed {
    logic [6:0] col;
    logic [3:0] base_lo;
  } hsplit_t;

  // Base-table search h -> 9*col; saturates at COLS for the right margin.
  function automatic hsplit_t h_split(input logic [9:0] h);
    h_split.col     = 7'd0;
    h_split.base_lo = 4'd0;
    for (int i = 1; i <= COLS; i++) begin
      if (int'(h) >= i * CHAR_W) begin
        h_split.col     = 7'(i);
        h_split.base_lo = 4'(i * CHAR_W);
      end
    end
  endfunction

  // Base table row -> 70*row.
  function automatic logic [12:0] row_base70(input logic [5:0] row);
    row_base70 = 13'd0;
    for (int i = 0; i < 64; i++) begin
      if (row == 6'(i)) row_base70 = 13'(i * COLS);
    end
  endfunction

  function automatic logic is_arrow(input logic [7:0] code);
    case (code)
      SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT: is_arrow = 1'b1;
      default:                           is_arrow = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] prompt_char(input logic [6:0] idx);
    if (int'(idx) < HEAD_LEN) prompt_char = PROMPT[8*(HEAD_LEN-1-int'(idx)) +: 8];
    else                      prompt_char = 8'h20;
  endfunction

  // 5x7 glyphs, five column bytes (first column in bits 39:32), bit 0 = top.
  // Anything outside 0x20..0x7E falls to the blank default.
  function automatic logic [39:0] font5x7(input logic [7:0] ch);
    case (ch)
      8'h20: font5x7 = 40'h0000000000; 8'h21: font5x7 = 40'h00005F0000; 8'h22: font5x7 = 40'h0007000700; 8'h23: font5x7 = 40'h147F147F14;
      8'h24: font5x7 = 40'h242A7F2A12; 8'h25: font5x7 = 40'h2313086462; 8'h26: font5x7 = 40'h3649562050; 8'h27: font5x7 = 40'h0005030000;
      8'h28: font5x7 = 40'h001C224100; 8'h29: font5x7 = 40'h0041221C00; 8'h2A: font5x7 = 40'h2A1C7F1C2A; 8'h2B: font5x7 = 40'h08083E0808;
      8'h2C: font5x7 = 40'h0050300000; 8'h2D: font5x7 = 40'h0808080808; 8'h2E: font5x7 = 40'h0060600000; 8'h2F: font5x7 = 40'h2010080402;
      8'h30: font5x7 = 40'h3E5149453E; 8'h31: font5x7 = 40'h00427F4000; 8'h32: font5x7 = 40'h4261514946; 8'h33: font5x7 = 40'h2141454B31;
      8'h34: font5x7 = 40'h1814127F10; 8'h35: font5x7 = 40'h2745454539; 8'h36: font5x7 = 40'h3C4A494930; 8'h37: font5x7 = 40'h0171090503;
      8'h38: font5x7 = 40'h3649494936; 8'h39: font5x7 = 40'h064949291E; 8'h3A: font5x7 = 40'h0036360000; 8'h3B: font5x7 = 40'h0056360000;
      8'h3C: font5x7 = 40'h0814224100; 8'h3D: font5x7 = 40'h1414141414; 8'h3E: font5x7 = 40'h0041221408; 8'h3F: font5x7 = 40'h0201510906;
      8'h40: font5x7 = 40'h3E415D594E; 8'h41: font5x7 = 40'h7C1211127C; 8'h42: font5x7 = 40'h7F49494936; 8'h43: font5x7 = 40'h3E41414122;
      8'h44: font5x7 = 40'h7F4141221C; 8'h45: font5x7 = 40'h7F49494941; 8'h46: font5x7 = 40'h7F09090901; 8'h47: font5x7 = 40'h3E4149497A;
      8'h48: font5x7 = 40'h7F0808087F; 8'h49: font5x7 = 40'h00417F4100; 8'h4A: font5x7 = 40'h2040413F01; 8'h4B: font5x7 = 40'h7F08142241;
      8'h4C: font5x7 = 40'h7F40404040; 8'h4D: font5x7 = 40'h7F021C027F; 8'h4E: font5x7 = 40'h7F0408107F; 8'h4F: font5x7 = 40'h3E4141413E;
      8'h50: font5x7 = 40'h7F09090906; 8'h51: font5x7 = 40'h3E4151215E; 8'h52: font5x7 = 40'h7F09192946; 8'h53: font5x7 = 40'h4649494931;
      8'h54: font5x7 = 40'h01017F0101; 8'h55: font5x7 = 40'h3F4040403F; 8'h56: font5x7 = 40'h1F2040201F; 8'h57: font5x7 = 40'h3F4038403F;
      8'h58: font5x7 = 40'h6314081463; 8'h59: font5x7 = 40'h0708700807; 8'h5A: font5x7 = 40'h6151494543; 8'h5B: font5x7 = 40'h007F414100;
      8'h5C: font5x7 = 40'h0204081020; 8'h5D: font5x7 = 40'h0041417F00; 8'h5E: font5x7 = 40'h0402010204; 8'h5F: font5x7 = 40'h4040404040;
      8'h60: font5x7 = 40'h0001020400; 8'h61: font5x7 = 40'h2054545478; 8'h62: font5x7 = 40'h7F48444438; 8'h63: font5x7 = 40'h3844444420;
      8'h64: font5x7 = 40'h384444487F; 8'h65: font5x7 = 40'h3854545418; 8'h66: font5x7 = 40'h087E090102; 8'h67: font5x7 = 40'h0C5252523E;
      8'h68: font5x7 = 40'h7F08040478; 8'h69: font5x7 = 40'h00447D4000; 8'h6A: font5x7 = 40'h2040443D00; 8'h6B: font5x7 = 40'h7F10284400;
      8'h6C: font5x7 = 40'h00417F4000; 8'h6D: font5x7 = 40'h7C04180478; 8'h6E: font5x7 = 40'h7C08040478; 8'h6F: font5x7 = 40'h3844444438;
      8'h70: font5x7 = 40'h7C14141408; 8'h71: font5x7 = 40'h081414187C; 8'h72: font5x7 = 40'h7C08040408; 8'h73: font5x7 = 40'h4854545420;
      8'h74: font5x7 = 40'h043F444020; 8'h75: font5x7 = 40'h3C4040207C; 8'h76: font5x7 = 40'h1C2040201C; 8'h77: font5x7 = 40'h3C4030403C;
      8'h78: font5x7 = 40'h4428102844; 8'h79: font5x7 = 40'h0C5050503C; 8'h7A: font5x7 = 40'h4464544C44; 8'h7B: font5x7 = 40'h0008364100;
      8'h7C: font5x7 = 40'h00007F0000; 8'h7D: font5x7 = 40'h0041360800; 8'h7E: font5x7 = 40'h08082A1C08;
      default: font5x7 = 40'h0000000000;
    endcase
  endfunction

  // One 9-bit cell row from ROM address {char, row}. The 5x7 glyph is doubled
  // vertically into rows 1..14 and placed at pixel columns 1..5; bit 0 is the
  // leftmost pixel and bit 8 (spacing column) stays 0.
  function automatic logic [8:0] glyph_row(input logic [11:0] addr);
    logic [39:0] cols;
    logic [3:0]  row;
    logic [2:0]  src;
    glyph_row = 9'd0;
    cols      = font5x7(addr[11:4]);
    row       = addr[3:0];
    src       = 3'((row - 4'd1) >> 1);
    if ((row >= 4'd1) && (row <= 4'd14)) begin
      for (int c = 0; c < 5; c++) glyph_row[c + 1] = cols[32 - 8*c + int'(src)];
    end else begin
      glyph_row = 9'd0;
    end
  endfunction

  // Pixel pick from a cell row; offsets past the cell read as background.
  function automatic logic pick_bit(input logic [8:0] row, input logic [3:0] col);
    if (col < 4'd9) pick_bit = row[col];
    else            pick_bit = 1'b0;
  endfunction

endpackage

// File: rtl/video_memory_storage_if.sv
// -----------------------------------------------------------------------------
// video_memory_storage_if
// Bus between the VGA/console side (master) and the pixel generator (slave).
// master drives: h_addr, v_addr, roll_cnt, show_ascii, scan_code_e0,
//                color_background, color_text
// slave drives:  keys_x, keys_y, keys_index, offset_x, offset_y, showcolor,
//                showcolor_header, direction_flag
// -----------------------------------------------------------------------------
interface video_memory_storage_if;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic [12:0] roll_cnt;
  logic [7:0]  show_ascii;
  logic [7:0]  scan_code_e0;
  logic [23:0] color_background;
  logic [23:0] color_text;
  logic [7:0]  keys_x;
  logic [7:0]  keys_y;
  logic [12:0] keys_index;
  logic [7:0]  offset_x;
  logic [7:0]  offset_y;
  logic [23:0] showcolor;
  logic [23:0] showcolor_header;
  logic        direction_flag;

  modport master (
    output h_addr, v_addr, roll_cnt, show_ascii, scan_code_e0, color_background, color_text,
    input  keys_x, keys_y, keys_index, offset_x, offset_y, showcolor, showcolor_header, direction_flag
  );

  modport slave (
    input  h_addr, v_addr, roll_cnt, show_ascii, scan_code_e0, color_background, color_text,
    output keys_x, keys_y, keys_index, offset_x, offset_y, showcolor, showcolor_header, direction_flag
  );
endinterface

// File: rtl/video_memory_storage_font_rom.sv
// -----------------------------------------------------------------------------
// font_rom
// Synchronous 4096 x 9 font ROM, one read port, address = char*16 + row.
// Ports: clk, rst (async, active high, clears the read register),
//        addr[11:0] in, data[8:0] out (one clock after addr).
// -----------------------------------------------------------------------------
module font_rom
  import console_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  output logic [8:0]  data
);

  // Registered glyph-row read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data <= 9'd0;
    else     data <= glyph_row(addr);
  end

endmodule

// File: rtl/video_memory_storage.sv
// -----------------------------------------------------------------------------
// video_memory_storage
// Text-mode pixel generator. Stage 1 splits the scan position into cell
// coordinates and a character-RAM index; stage 2 reads the font ROM for the
// character (from the external RAM) and for the fixed prompt, and selects
// the text and prompt pixel colours.
// Ports: clk, rst (async, active high), bus (video_memory_storage_if.slave).
// -----------------------------------------------------------------------------
module video_memory_storage
  import console_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  video_memory_storage_if.slave  bus
);

  hsplit_t     hsplit_s;
  logic [5:0]  row_s;
  logic [3:0]  ofs_x_s;
  logic [12:0] index_s;

  logic [6:0]  keys_x_r;
  logic [5:0]  keys_y_r;
  logic [12:0] keys_index_r;
  logic [3:0]  ofs_x_r;
  logic [3:0]  ofs_y_r;
  logic        visible_r;

  logic [3:0]  ofs_x_d_r;
  logic        text_en_r;
  logic        head_en_r;
  logic [23:0] fg_r;
  logic [23:0] bg_r;

  logic [8:0]  text_row_s;
  logic [8:0]  head_row_s;
  logic        text_pix_s;
  logic        head_pix_s;

  // Stage-1 decode. The in-cell column is h - 9*col, which never exceeds 9,
  // so the 4-bit modular difference of the low bits is exact.
  always_comb begin
    hsplit_s = h_split(bus.h_addr);
    row_s    = bus.v_addr[9:4];
    ofs_x_s  = bus.h_addr[3:0] - hsplit_s.base_lo;
    index_s  = bus.roll_cnt + row_base70(row_s) + {6'd0, hsplit_s.col};
  end

  // Stage-1 registers: cell coordinates, RAM index, in-cell offsets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_x_r     <= 7'd0;
      keys_y_r     <= 6'd0;
      keys_index_r <= 13'd0;
      ofs_x_r      <= 4'd0;
      ofs_y_r      <= 4'd0;
      visible_r    <= 1'b0;
    end else begin
      keys_x_r     <= hsplit_s.col;
      keys_y_r     <= row_s;
      keys_index_r <= index_s;
      ofs_x_r      <= ofs_x_s;
      ofs_y_r      <= bus.v_addr[3:0];
      visible_r    <= (bus.v_addr < 10'(ROWS_VISIBLE * CHAR_H));
    end
  end

  // Text glyph: the character RAM answers combinationally on keys_index.
  font_rom u_text_rom (
    .clk  (clk),
    .rst  (rst),
    .addr ({bus.show_ascii, ofs_y_r}),
    .data (text_row_s)
  );

  font_rom u_head_rom (
    .clk  (clk),
    .rst  (rst),
    .addr ({prompt_char(keys_x_r), ofs_y_r}),
    .data (head_row_s)
  );

  // Stage-2 registers aligned with the ROM reads; colours are sampled here.
  // keys_x == COLS marks the right margin, which shows background only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofs_x_d_r <= 4'd0;
      text_en_r <= 1'b0;
      head_en_r <= 1'b0;
      fg_r      <= 24'h000000;
      bg_r      <= 24'h000000;
    end else begin
      ofs_x_d_r <= ofs_x_r;
      text_en_r <= visible_r & (keys_x_r != 7'(COLS));
      head_en_r <= visible_r & (keys_x_r < 7'(HEAD_LEN));
      fg_r      <= bus.color_text;
      bg_r      <= bus.color_background;
    end
  end

  // Pixel selection from stage-2 state only (no input-to-output path).
  always_comb begin
    text_pix_s = text_en_r & pick_bit(text_row_s, ofs_x_d_r);
    head_pix_s = head_en_r & pick_bit(head_row_s, ofs_x_d_r);
  end

  assign bus.keys_x           = {1'b0, keys_x_r};
  assign bus.keys_y           = {2'b00, keys_y_r};
  assign bus.keys_index       = keys_index_r;
  assign bus.offset_x         = {4'd0, ofs_x_r};
  assign bus.offset_y         = {4'd0, ofs_y_r};
  assign bus.showcolor        = text_pix_s ? fg_r : bg_r;
  assign bus.showcolor_header = head_pix_s ? HEADER_COLOR : bg_r;
  assign bus.direction_flag   = is_arrow(bus.scan_code_e0);

endmodule

// File: tb/tb_video_memory_storage.sv
// -----------------------------------------------------------------------------
// tb_video_memory_storage
// Directed bench for video_memory_storage. Glyph shapes for 'A' and 'M' are
// written out by hand as 7 rows x 5 columns (bit c = glyph column c, pixel
// column c+1, rows doubled into cell rows 1..14).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_memory_storage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  localparam logic [23:0] FG  = 24'hABCDEF;
  localparam logic [23:0] BG  = 24'h102030;
  localparam logic [23:0] HDR = 24'h00FF00;
  // rows 6..0 from MSB to LSB
  localparam logic [34:0] GLYPH_A = {5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b01010, 5'b00100};
  localparam logic [34:0] GLYPH_M = {5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b11011, 5'b10001};

  video_memory_storage_if vif();

  video_memory_storage dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  function automatic bit exp_pix(input int x, input int y, input logic [34:0] g);
    if (y >= 1 && y <= 14 && x >= 1 && x <= 5) return g[((y - 1) / 2) * 5 + (x - 1)];
    return 1'b0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int h, input int v, input int roll);
    vif.h_addr   = 10'(h);
    vif.v_addr   = 10'(v);
    vif.roll_cnt = 13'(roll);
  endtask

  task automatic test_reset;
    vif.show_ascii = 8'h41; vif.scan_code_e0 = 8'h00;
    vif.color_background = BG; vif.color_text = FG;
    set_pos(100, 200, 70);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({vif.keys_x, vif.keys_y, vif.offset_x, vif.offset_y} !== 32'd0) begin
      errors++; $display("FAIL reset_coords: got %h want 0", {vif.keys_x, vif.keys_y, vif.offset_x, vif.offset_y});
    end
    checks++;
    if (vif.keys_index !== 13'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", vif.keys_index); end
    checks++;
    if (vif.showcolor !== 24'h0) begin errors++; $display("FAIL reset_showcolor: got %h want 0", vif.showcolor); end
    checks++;
    if (vif.showcolor_header !== 24'h0) begin errors++; $display("FAIL reset_header: got %h want 0", vif.showcolor_header); end
    checks++;
    if (vif.direction_flag !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b want 0", vif.direction_flag); end
    set_pos(0, 0, 0);
    vif.show_ascii = 8'h20;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (vif.keys_index !== 13'd0 || vif.offset_x !== 8'd0 || vif.offset_y !== 8'd0) begin
      errors++; $display("FAIL release_stage1: got idx=%0d ox=%0d oy=%0d want 0/0/0", vif.keys_index, vif.offset_x, vif.offset_y);
    end
    tick();
    checks++;
    if (vif.showcolor !== BG) begin errors++; $display("FAIL release_pixel: got %h want %h", vif.showcolor, BG); end
  endtask

  task automatic test_corner;
    set_pos(629, 479, 70);
    tick();
    checks++;
    if (vif.keys_x !== 8'd69 || vif.keys_y !== 8'd29) begin
      errors++; $display("FAIL corner_xy: got %0d,%0d want 69,29", vif.keys_x, vif.keys_y);
    end
    checks++;
    if (vif.offset_x !== 8'd8 || vif.offset_y !== 8'd15) begin
      errors++; $display("FAIL corner_ofs: got %0d,%0d want 8,15", vif.offset_x, vif.offset_y);
    end
    checks++;
    if (vif.keys_index !== 13'd2169) begin errors++; $display("FAIL corner_index: got %0d want 2169", vif.keys_index); end
  endtask

  task automatic test_char_a;
    logic [23:0] want;
    vif.show_ascii = 8'h41;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 9; x++) begin
        set_pos(9 + x, 16 + y, 0);
        tick();
        if (x == 1 && y == 1) begin
          checks++;
          if (vif.keys_index !== 13'd71 || vif.offset_x !== 8'd1 || vif.offset_y !== 8'd1) begin
            errors++; $display("FAIL a_stage1: got idx=%0d ox=%0d oy=%0d want 71/1/1", vif.keys_index, vif.offset_x, vif.offset_y);
          end
        end
        tick();
        want = exp_pix(x, y, GLYPH_A) ? FG : BG;
        checks++;
        if (vif.showcolor !== want) begin
          errors++; $display("FAIL a_pixel x=%0d y=%0d: got %h want %h", x, y, vif.showcolor, want);
        end
      end
    end
  endtask

  task automatic test_blank;
    logic [7:0] codes [4];
    codes = '{8'h00, 8'h20, 8'h7F, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      vif.show_ascii = codes[k];
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 9; x++) begin
          set_pos(x, y, 0);
          tick(); tick();
          checks++;
          if (vif.showcolor !== BG) begin
            errors++; $display("FAIL blank_%h x=%0d y=%0d: got %h want %h", codes[k], x, y, vif.showcolor, BG);
          end
        end
      end
    end
  endtask

  task automatic test_header;
    logic [23:0] want;
    vif.show_ascii = 8'h20;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 9; x++) begin
        set_pos(x, y, 0);
        tick(); tick();
        want = exp_pix(x, y, GLYPH_M) ? HDR : BG;
        checks++;
        if (vif.showcolor_header !== want) begin
          errors++; $display("FAIL header_m x=%0d y=%0d: got %h want %h", x, y, vif.showcolor_header, want);
        end
      end
    end
  endtask

  task automatic test_margin;
    vif.show_ascii = 8'h41;
    // in-range contrast: both outputs lit at h=2, v=3
    set_pos(2, 3, 0);
    tick(); tick();
    checks++;
    if (vif.showcolor !== FG || vif.showcolor_header !== HDR) begin
      errors++; $display("FAIL margin_ref: got %h/%h want %h/%h", vif.showcolor, vif.showcolor_header, FG, HDR);
    end
    for (int k = 0; k < 2; k++) begin
      set_pos(k == 0 ? 630 : 635, k == 0 ? 5 : 20, 0);
      tick();
      checks++;
      if (vif.keys_x !== 8'd70) begin errors++; $display("FAIL margin_keys_x: got %0d want 70", vif.keys_x); end
      tick();
      checks++;
      if (vif.showcolor !== BG || vif.showcolor_header !== BG) begin
        errors++; $display("FAIL margin_colour: got %h/%h want %h", vif.showcolor, vif.showcolor_header, BG);
      end
    end
    set_pos(2, 483, 0);
    tick();
    checks++;
    if (vif.keys_y !== 8'd30) begin errors++; $display("FAIL vlimit_keys_y: got %0d want 30", vif.keys_y); end
    tick();
    checks++;
    if (vif.showcolor !== BG || vif.showcolor_header !== BG) begin
      errors++; $display("FAIL vlimit_colour: got %h/%h want %h", vif.showcolor, vif.showcolor_header, BG);
    end
  endtask

  task automatic test_colour_change;
    vif.show_ascii = 8'h20;
    set_pos(0, 0, 0);
    tick(); tick();
    vif.color_background = 24'h445566;
    tick();
    checks++;
    if (vif.showcolor !== 24'h445566 || vif.showcolor_header !== 24'h445566) begin
      errors++; $display("FAIL bg_change: got %h/%h want 445566", vif.showcolor, vif.showcolor_header);
    end
    vif.show_ascii = 8'h41;
    set_pos(11, 3, 0);
    tick(); tick();
    vif.color_text = 24'h778899;
    tick();
    checks++;
    if (vif.showcolor !== 24'h778899) begin errors++; $display("FAIL fg_change: got %h want 778899", vif.showcolor); end
    vif.color_background = BG;
    vif.color_text = FG;
  endtask

  task automatic test_back_to_back;
    logic [23:0] want;
    vif.show_ascii = 8'h41;
    for (int i = 0; i < 9; i++) begin
      set_pos(9 + i, 20, 0);
      tick();
      checks++;
      if (vif.keys_x !== 8'd1 || vif.offset_x !== 8'(i)) begin
        errors++; $display("FAIL b2b_stage1 i=%0d: got x=%0d ox=%0d want 1/%0d", i, vif.keys_x, vif.offset_x, i);
      end
      if (i > 0) begin
        want = exp_pix(i - 1, 4, GLYPH_A) ? FG : BG;
        checks++;
        if (vif.showcolor !== want) begin
          errors++; $display("FAIL b2b_pixel i=%0d: got %h want %h", i - 1, vif.showcolor, want);
        end
      end
    end
    tick();
    checks++;
    if (vif.showcolor !== BG) begin errors++; $display("FAIL b2b_last: got %h want %h", vif.showcolor, BG); end
  endtask

  task automatic test_direction;
    logic [7:0] codes [6];
    logic       want  [6];
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h00};
    want  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      vif.scan_code_e0 = codes[k];
      #1;
      checks++;
      if (vif.direction_flag !== want[k]) begin
        errors++; $display("FAIL dir_%h: got %b want %b", codes[k], vif.direction_flag, want[k]);
      end
    end
    vif.scan_code_e0 = 8'h00;
  endtask

  initial begin
    test_reset();
    test_corner();
    test_char_a();
    test_blank();
    test_header();
    test_margin();
    test_colour_change();
    test_back_to_back();
    test_direction();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_memory_storage.md
Name: video_memory_storage

Overview:
- Text-mode pixel generator for the bash console. Converts the VGA scan position into a character cell, a character-RAM index and a pixel offset inside the cell.
- Looks up font bitmaps and produces the pixel colour for normal text and for the command-prompt header.
- Sits between the VGA controller and the console controller. The console controller owns the character RAM and the cursor logic.

Parameters:
- COLS, 70, characters per text row
- CHAR_W, 9, pixel width of a cell (8 glyph pixels plus 1 spacing column)
- CHAR_H, 16, pixel height of a cell
- HEAD_LEN, 9, prompt length in characters
- HEADER_COLOR, 24'h00FF00, prompt glyph colour

Ports:
- clk input 1: system clock
- rst input 1: asynchronous, active-high reset
- h_addr input 10: VGA column, 0..639
- v_addr input 10: VGA row, 0..479
- roll_cnt input 13: scroll offset in characters (multiple of 70)
- show_ascii input 8: character at keys_index; must be driven combinationally by the character RAM
- scan_code_e0 input 8: extended keyboard scan code
- color_background input 24: current background colour
- color_text input 24: current text colour
- keys_x output 8: character column
- keys_y output 8: character row
- keys_index output 13: character-RAM index
- offset_x output 8: pixel column inside the cell
- offset_y output 8: pixel row inside the cell
- showcolor output 24: text pixel colour
- showcolor_header output 24: prompt pixel colour
- direction_flag output 1: arrow key present

Behaviour:
- Stage 1 (registered, latency 1 clock from h_addr/v_addr):
  - keys_x = h_addr/9, keys_y = v_addr/16.
  - offset_x = h_addr − 9·keys_x, offset_y = v_addr − 16·keys_y.
  - keys_index = roll_cnt + 70·keys_y + keys_x, truncated to 13 bits.
  - Division is implemented with base-lookup tables (h→9·col, v→16·row, row→70·row), not with dividers.
- Stage 2 (registered, latency 2 clocks):
  - Font ROM address = show_ascii·16 + offset_y. The ROM has 256 glyphs × 16 rows × 9 bits.
  - Bit offset_x of the row is the pixel; bit 0 is the leftmost pixel and bit 8 is always 0.
  - showcolor = pixel ? color_text : color_background.
- Characters 0x00–0x1F and 0x7F–0xFF render blank (all rows zero).
- Prompt string is "MYS@bash$", fixed in ROM.
  - For keys_x < 9, the glyph is prompt[keys_x].
  - showcolor_header = pixel ? HEADER_COLOR : color_background, at the same 2-clock latency.
  - For keys_x ≥ 9, showcolor_header = color_background.
- Right margin: if h_addr ≥ 630, keys_x = 70 and both colour outputs are color_background. keys_index is still computed.
- If v_addr ≥ 480, both colour outputs are color_background.
- direction_flag is combinational: 1 iff scan_code_e0 ∈ {0x75, 0x72, 0x6B, 0x74}.
- Reset clears all registered outputs to 0 (colours to 24'h0) immediately. After release, the first valid pixel appears 2 clocks later.
- Colour inputs are sampled in stage 2, so a colour change takes effect on the next pixel.
- No internal state beyond the pipeline registers and ROMs; no backpressure.

Decomposition:
- Shared package console_pkg holds:
  - the constants COLS, CHAR_W, CHAR_H, HEAD_LEN, ROWS_VISIBLE=30, VISIBLE_W=630
  - the arrow scan codes
  - the prompt string constant
- One sub-module, font_rom: synchronous 4096×9 ROM with a single read port, used twice (text and header) or dual-ported.

Test Plan:
- rst=1 mid-stream, with non-zero h/v → all outputs 0 immediately. After release with h=0, v=0, roll=0 → after 1 clk keys_index=0, offset_x=0, offset_y=0.
- h=629, v=479, roll=70 → keys_x=69, keys_y=29, offset_x=8, offset_y=15, keys_index=2169.
- h=10, v=17, roll=0, show_ascii=0x41 ('A') → keys_index=71, offset_x=1, offset_y=1. Two clocks after h/v are applied, showcolor equals color_text where the 'A' glyph bit is set and color_background elsewhere; offset_x=8 always gives background.
- show_ascii=0x00 and show_ascii=0x20 → showcolor=color_background for every offset.
- h=0..8, v=0..15 → showcolor_header renders 'M' in HEADER_COLOR. With h=630 (keys_x=70), showcolor and showcolor_header both equal color_background.
- scan_code_e0 = 0x75, 0x72, 0x6B, 0x74 → direction_flag=1. scan_code_e0 = 0x5A or 0x00 → direction_flag=0.
